// File: rtl/text_vram_ctrl_pkg.sv
// Shared definitions for the text video-memory controller: screen geometry
// defaults, ASCII control codes, FSM state and cursor command encodings.
package text_pkg;

  localparam int COLS_DEF = 70;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    NEWLINE,
    BKSP,
    ERASE,
    CLEAR
  } state_e;

  typedef enum logic [1:0] {
    CUR_NONE,
    CUR_ADV,
    CUR_NL,
    CUR_BACK
  } cur_cmd_e;

  // Linear video-memory index of a character cell.
  function automatic logic [11:0] cell_addr(input logic [6:0] col,
                                            input logic [4:0] row,
                                            input int cols);
    return 12'(row) * 12'(cols) + 12'(col);
  endfunction

endpackage

// File: rtl/text_vram_ctrl_if.sv
// Keyboard handshake, video-memory write port and cursor/status signals of
// the text controller. master = keyboard/host side, slave = controller.
interface text_vram_ctrl_if;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic        key_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  modport master (
    output key_valid, key_ascii,
    input  key_ready, wr_en, wr_addr, wr_data, cur_col, cur_row, busy
  );

  modport slave (
    input  key_valid, key_ascii,
    output key_ready, wr_en, wr_addr, wr_data, cur_col, cur_row, busy
  );
endinterface

// File: rtl/text_vram_ctrl_cursor.sv
// Cursor position counter. Applies one command per cycle (advance, newline,
// back one cell) and exposes the next position so the FSM can address the
// cell the cursor is about to land on.
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  cur_cmd_e   cmd_i,
  output logic [6:0] col_o,
  output logic [4:0] row_o,
  output logic [6:0] col_d_o,
  output logic [4:0] row_d_o,
  output logic       row_adv_o
);

  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic       row_adv;

  // Next cursor position for the requested command, row wrap included.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    row_adv = 1'b0;
    unique case (cmd_i)
      CUR_ADV: begin
        if (col_q == 7'(COLS - 1)) begin
          col_d   = '0;
          row_adv = 1'b1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      CUR_NL: begin
        col_d   = '0;
        row_adv = 1'b1;
      end
      CUR_BACK: begin
        if (col_q != '0) begin
          col_d = col_q - 7'd1;
        end else if (row_q != '0) begin
          col_d = 7'(COLS - 1);
          row_d = row_q - 5'd1;
        end
      end
      default: ;
    endcase
    if (row_adv) begin
      row_d = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
    end
  end

  // Cursor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o     = col_q;
  assign row_o     = row_q;
  assign col_d_o   = col_d;
  assign row_d_o   = row_d;
  assign row_adv_o = row_adv;

endmodule

// File: rtl/text_vram_ctrl.sv
// Keyboard-to-text-screen controller. Accepts ASCII codes, writes printable
// characters at the cursor, handles CR/LF and backspace, and drives a
// registered video-memory write port.
// Build option: TEXT_VRAM_CLEAR_ON_WRAP_EN blanks every newly entered row.
//
// state   | meaning
// IDLE    | waiting for a key code (key_ready=1)
// WRITE   | character write at cursor, cursor advances at end
// NEWLINE | col=0 and row advance, no write
// BKSP    | cursor steps back one cell, no write
// ERASE   | space written at the new cursor cell
// CLEAR   | spaces written across the newly entered row
module text_vram_ctrl
  import text_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input logic           clk,
  input logic           rst,
  text_vram_ctrl_if.slave bus
);

`ifdef TEXT_VRAM_CLEAR_ON_WRAP_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  cur_cmd_e    cmd;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        row_adv;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [6:0]  clr_left_q, clr_left_d;
  logic        printable;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk),
    .rst      (rst),
    .cmd_i    (cmd),
    .col_o    (col_q),
    .row_o    (row_q),
    .col_d_o  (col_d),
    .row_d_o  (row_d),
    .row_adv_o(row_adv)
  );

  assign printable = (bus.key_ascii >= 8'h20) && (bus.key_ascii <= 8'h7E);

  // Next state, cursor command and next values of the registered write port.
  always_comb begin
    state_d    = state_q;
    cmd        = CUR_NONE;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    clr_left_d = clr_left_q;
    unique case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          if (printable) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr(col_q, row_q, COLS);
            wr_data_d = bus.key_ascii;
          end else if (bus.key_ascii == CR || bus.key_ascii == LF) begin
            state_d = NEWLINE;
          end else if (bus.key_ascii == BS) begin
            state_d = BKSP;
          end
        end
      end
      WRITE, NEWLINE: begin
        cmd = (state_q == WRITE) ? CUR_ADV : CUR_NL;
        if (CLEAR_EN && row_adv) begin
          state_d    = CLEAR;
          wr_en_d    = 1'b1;
          wr_addr_d  = cell_addr(7'd0, row_d, COLS);
          wr_data_d  = SPACE;
          clr_left_d = 7'(COLS - 1);
        end else begin
          state_d = IDLE;
        end
      end
      BKSP: begin
        cmd       = CUR_BACK;
        state_d   = ERASE;
        wr_en_d   = 1'b1;
        wr_addr_d = cell_addr(col_d, row_d, COLS);
        wr_data_d = SPACE;
      end
      ERASE: begin
        state_d = IDLE;
      end
      CLEAR: begin
        if (clr_left_q == '0) begin
          state_d = IDLE;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = wr_addr_q + 12'd1;
          clr_left_d = clr_left_q - 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      clr_left_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      clr_left_q <= clr_left_d;
    end
  end

  assign bus.key_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cur_col   = col_q;
  assign bus.cur_row   = row_q;

endmodule
